// File: rtl/sap_exec_core.sv
// SAP-1 execution core: 6-state sequencer, control decode, accumulator and add/sub ALU.
// Optional SAP_TRACE_EN compiles in simulation-only $display tracing.
module sap_exec_core (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_program_mode,
  input  logic [3:0] i_opcode,
  input  logic [7:0] i_bus,
  input  logic [7:0] i_b,
  output logic [7:0] o_bus,
  output logic       o_bus_en,
  output logic       o_pc_incr,
  output logic       o_pc_enable,
  output logic       o_mar_load,
  output logic       o_ram_enable,
  output logic       o_ir_load,
  output logic       o_ir_send,
  output logic       o_b_load,
  output logic       o_out_load,
  output logic [7:0] o_acc,
  output logic [5:0] o_tstate,
  output logic       o_halted
);

  localparam logic [3:0] OpLda = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpOut = 4'b1110;
  localparam logic [3:0] OpHlt = 4'b1111;

  typedef enum logic [2:0] {StT1, StT2, StT3, StT4, StT5, StT6} tstate_e;

  tstate_e     state_q, state_d;
  logic        halted_q, halted_d;
  logic [7:0]  acc_q, acc_d;
  logic        active;
  logic        acc_load, acc_send, alu_send, subtract;
  logic        is_lda, is_arith;
  logic [7:0]  alu_result;

  assign is_lda   = (i_opcode == OpLda);
  assign is_arith = (i_opcode == OpAdd) || (i_opcode == OpSub);
  // Reset is folded in so the T1 decode does not leak while reset is held.
  assign active   = i_reset_n && i_program_mode && !halted_q;

  always_comb begin
    state_d      = state_q;
    halted_d     = halted_q;
    o_pc_incr    = 1'b0;
    o_pc_enable  = 1'b0;
    o_mar_load   = 1'b0;
    o_ram_enable = 1'b0;
    o_ir_load    = 1'b0;
    o_ir_send    = 1'b0;
    o_b_load     = 1'b0;
    o_out_load   = 1'b0;
    acc_load     = 1'b0;
    acc_send     = 1'b0;
    alu_send     = 1'b0;
    subtract     = 1'b0;

    if (halted_q) begin
      state_d = state_q;
    end else if (!i_program_mode) begin
      state_d = StT1;
    end else begin
      unique case (state_q)
        StT1:    state_d = StT2;
        StT2:    state_d = StT3;
        StT3:    state_d = StT4;
        StT4:    state_d = StT5;
        StT5:    state_d = StT6;
        default: state_d = StT1;
      endcase
    end

    if (active) begin
      unique case (state_q)
        StT1: begin
          o_pc_enable = 1'b1;
          o_mar_load  = 1'b1;
        end
        StT2: o_pc_incr = 1'b1;
        StT3: begin
          o_ram_enable = 1'b1;
          o_ir_load    = 1'b1;
        end
        StT4: begin
          if (is_lda || is_arith) begin
            o_ir_send  = 1'b1;
            o_mar_load = 1'b1;
          end else if (i_opcode == OpOut) begin
            acc_send   = 1'b1;
            o_out_load = 1'b1;
          end else if (i_opcode == OpHlt) begin
            halted_d = 1'b1;
          end
        end
        StT5: begin
          if (is_lda) begin
            o_ram_enable = 1'b1;
            acc_load     = 1'b1;
          end else if (is_arith) begin
            o_ram_enable = 1'b1;
            o_b_load     = 1'b1;
          end
        end
        default: begin
          if (is_arith) begin
            alu_send = 1'b1;
            acc_load = 1'b1;
            subtract = (i_opcode == OpSub);
          end
        end
      endcase
    end
  end

  // Two's-complement subtract: acc + ~B + 1, carry dropped by the 8-bit width.
  assign alu_result = acc_q + (subtract ? ~i_b : i_b) + {7'd0, subtract};
  assign acc_d      = acc_load ? i_bus : acc_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StT1;
      halted_q <= 1'b0;
      acc_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    o_tstate = 6'b000000;
    unique case (state_q)
      StT1:    o_tstate = 6'b000001;
      StT2:    o_tstate = 6'b000010;
      StT3:    o_tstate = 6'b000100;
      StT4:    o_tstate = 6'b001000;
      StT5:    o_tstate = 6'b010000;
      default: o_tstate = 6'b100000;
    endcase
  end

  assign o_bus_en = acc_send || alu_send;
  assign o_bus    = !i_reset_n ? 8'h00 : (acc_send ? acc_q : alu_result);
  assign o_acc    = acc_q;
  assign o_halted = halted_q;

`ifdef SAP_TRACE_EN
  always @(posedge i_clk) begin
    if (i_reset_n) begin
      if (state_d != state_q)
        $display("sap: T%0d -> T%0d op=%b", int'(state_q) + 1, int'(state_d) + 1, i_opcode);
      if (acc_load) $display("sap: acc <= %02h", i_bus);
      if (o_bus_en) $display("sap: bus %02h from %s", o_bus, acc_send ? "acc" : "alu");
      if (halted_d && !halted_q) $display("sap: halt");
    end
  end
`else
  // Tracing disabled: nothing extra is elaborated.
`endif

endmodule

// File: tb/tb_sap_exec_core.sv
// Self-checking bench for sap_exec_core: vector table, randomized instruction stream
// against an instruction-level model, and hand-written halt/program-mode/reset sequences.
module tb_sap_exec_core;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_program_mode;
  logic [3:0] i_opcode;
  logic [7:0] i_bus, i_b, ext_bus;
  logic [7:0] o_bus, o_acc;
  logic       o_bus_en, o_halted;
  logic       o_pc_incr, o_pc_enable, o_mar_load, o_ram_enable;
  logic       o_ir_load, o_ir_send, o_b_load, o_out_load;
  logic [5:0] o_tstate;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_acc;

  always #5 i_clk = ~i_clk;

  // Bus loopback: whoever the DUT says owns the bus, otherwise the bench's RAM data.
  assign i_bus = o_bus_en ? o_bus : ext_bus;

  sap_exec_core dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_program_mode (i_program_mode),
    .i_opcode       (i_opcode),
    .i_bus          (i_bus),
    .i_b            (i_b),
    .o_bus          (o_bus),
    .o_bus_en       (o_bus_en),
    .o_pc_incr      (o_pc_incr),
    .o_pc_enable    (o_pc_enable),
    .o_mar_load     (o_mar_load),
    .o_ram_enable   (o_ram_enable),
    .o_ir_load      (o_ir_load),
    .o_ir_send      (o_ir_send),
    .o_b_load       (o_b_load),
    .o_out_load     (o_out_load),
    .o_acc          (o_acc),
    .o_tstate       (o_tstate),
    .o_halted       (o_halted)
  );

  wire [7:0] ctrl = {o_pc_incr, o_pc_enable, o_mar_load, o_ram_enable,
                     o_ir_load, o_ir_send, o_b_load, o_out_load};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected control word {Cp,Ep,Lm,CE,Li,Ei,Lb,Lo} for T-state t (1..6).
  function automatic logic [7:0] exp_ctrl(input int t, input logic [3:0] op);
    logic mem_op = (op == LDA) || (op == ADD) || (op == SUB);
    case (t)
      1: return 8'h60;
      2: return 8'h80;
      3: return 8'h18;
      4: return mem_op ? 8'h24 : (op == OUT ? 8'h01 : 8'h00);
      5: return (op == LDA) ? 8'h10 : ((op == ADD || op == SUB) ? 8'h12 : 8'h00);
      default: return 8'h00;
    endcase
  endfunction

  // One T-state: called at a negedge, returns at the following negedge.
  task automatic step(input int t, input logic [3:0] op, input logic [7:0] b,
                      input logic [7:0] data);
    logic       exp_en;
    logic [7:0] exp_bus;
    logic [5:0] onehot;
    i_opcode = op;
    i_b      = b;
    ext_bus  = data;
    #1;
    onehot  = 6'b000001 << (t - 1);
    exp_en  = (t == 4 && op == OUT) || (t == 6 && (op == ADD || op == SUB));
    exp_bus = (op == OUT) ? model_acc : (op == SUB ? model_acc - b : model_acc + b);
    chk("tstate", {2'b00, o_tstate}, {2'b00, onehot});
    chk("ctrl", ctrl, exp_ctrl(t, op));
    chk("bus_en", {7'd0, o_bus_en}, {7'd0, exp_en});
    if (exp_en) chk("bus", o_bus, exp_bus);
    chk("acc", o_acc, model_acc);
    chk("halted", {7'd0, o_halted}, 8'h00);
    @(posedge i_clk);
    if (t == 5 && op == LDA) model_acc = data;
    if (t == 6 && (op == ADD || op == SUB)) model_acc = exp_bus;
    @(negedge i_clk);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [7:0] b, input logic [7:0] data);
    for (int t = 1; t <= 6; t++) step(t, op, b, data);
  endtask

  task automatic reset_held_checks();
    chk("rst_tstate", {2'b00, o_tstate}, 8'h01);
    chk("rst_acc", o_acc, 8'h00);
    chk("rst_ctrl", ctrl, 8'h00);
    chk("rst_bus_en", {7'd0, o_bus_en}, 8'h00);
    chk("rst_bus", o_bus, 8'h00);
    chk("rst_halted", {7'd0, o_halted}, 8'h00);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    reset_held_checks();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_acc = 8'h00;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] acc0;
    logic [7:0] b;
    logic [7:0] data;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{op: LDA, acc0: 8'h00, b: 8'h00, data: 8'h2A, exp_acc: 8'h2A};
    vecs[1] = '{op: ADD, acc0: 8'h2A, b: 8'h10, data: 8'h00, exp_acc: 8'h3A};
    vecs[2] = '{op: ADD, acc0: 8'hF0, b: 8'h20, data: 8'h00, exp_acc: 8'h10};
    vecs[3] = '{op: SUB, acc0: 8'h05, b: 8'h07, data: 8'h00, exp_acc: 8'hFE};
    vecs[4] = '{op: OUT, acc0: 8'h5C, b: 8'h33, data: 8'h00, exp_acc: 8'h5C};
    vecs[5] = '{op: 4'h7, acc0: 8'h81, b: 8'h11, data: 8'h99, exp_acc: 8'h81};
    vecs[6] = '{op: SUB, acc0: 8'h40, b: 8'h40, data: 8'h00, exp_acc: 8'h00};

    i_reset_n      = 1'b0;
    i_program_mode = 1'b1;
    i_opcode       = LDA;
    i_b            = 8'h00;
    ext_bus        = 8'h00;
    model_acc      = 8'h00;
    @(negedge i_clk);
    do_reset();

    // Table vectors: preload acc with LDA, then the instruction under test.
    for (int i = 0; i < 7; i++) begin
      run_instr(LDA, 8'h00, vecs[i].acc0);
      run_instr(vecs[i].op, vecs[i].b, vecs[i].data);
      chk("vec_acc", o_acc, vecs[i].exp_acc);
    end

    // Randomized instruction stream against the instruction-level model.
    for (int n = 0; n < 150; n++) begin
      int unsigned r = $urandom_range(0, 9);
      logic [3:0] op;
      if (r < 3) op = LDA;
      else if (r < 5) op = ADD;
      else if (r < 7) op = SUB;
      else if (r < 8) op = OUT;
      else op = 4'($urandom_range(3, 13));
      run_instr(op, 8'($urandom), 8'($urandom));
    end

    // Program mode dropped mid-instruction parks the sequencer at T1.
    run_instr(LDA, 8'h00, 8'h3C);
    step(1, LDA, 8'h00, 8'hAA);
    step(2, LDA, 8'h00, 8'hAA);
    i_program_mode = 1'b0;
    #1;
    chk("pm_tstate_t3", {2'b00, o_tstate}, 8'h04);
    chk("pm_ctrl", ctrl, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk("pm_tstate_park", {2'b00, o_tstate}, 8'h01);
      chk("pm_ctrl_park", ctrl, 8'h00);
      chk("pm_acc", o_acc, 8'h3C);
    end
    i_program_mode = 1'b1;
    run_instr(ADD, 8'h01, 8'h00);
    chk("pm_resume_acc", o_acc, 8'h3D);

    // Asynchronous reset in the middle of T3.
    step(1, SUB, 8'h02, 8'h00);
    step(2, SUB, 8'h02, 8'h00);
    i_reset_n = 1'b0;
    #1;
    reset_held_checks();
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_acc = 8'h00;
    run_instr(ADD, 8'h09, 8'h00);
    chk("post_rst_acc", o_acc, 8'h09);

    // HLT freezes at T5 with all controls low until reset.
    for (int t = 1; t <= 4; t++) step(t, HLT, 8'h00, 8'h00);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("hlt_tstate", {2'b00, o_tstate}, 8'h10);
      chk("hlt_halted", {7'd0, o_halted}, 8'h01);
      chk("hlt_ctrl", ctrl, 8'h00);
      chk("hlt_bus_en", {7'd0, o_bus_en}, 8'h00);
      chk("hlt_acc", o_acc, 8'h09);
      @(posedge i_clk);
      @(negedge i_clk);
    end
    do_reset();
    run_instr(LDA, 8'h00, 8'h42);
    chk("after_hlt_acc", o_acc, 8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_exec_core.md
# sap_exec_core

Execution core of the SAP-1 computer: the 6-state instruction sequencer, the 8-bit accumulator and the add/subtract ALU in one block. It decodes the 4-bit opcode from the instruction register and emits the control word for the program counter, MAR, RAM, instruction register, B register and output register. It drives the shared 8-bit bus through an explicit output-enable instead of an internal tri-state.

## Interface
- No parameters. Data width is fixed at 8 bits, opcode width at 4 bits.
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_program_mode  in  1  0 = program mode (sequencer parked), 1 = execute.
- i_opcode  in  4  opcode from the instruction register.
- i_bus  in  8  resolved system bus value.
- i_b  in  8  unbuffered B-register contents (ALU operand B).
- o_bus  out  8  value this block drives onto the bus.
- o_bus_en  out  1  o_bus is valid and must own the bus.
- o_pc_incr, o_pc_enable, o_mar_load, o_ram_enable  out  1 each  control lines Cp, Ep, Lm, CE.
- o_ir_load, o_ir_send, o_b_load, o_out_load  out  1 each  control lines Li, Ei, Lb, Lo.
- o_acc  out  8  unbuffered accumulator contents.
- o_tstate  out  6  one-hot T-state; bit0 = T1.
- o_halted  out  1  HLT executed.

## Operation
- Opcodes:
  - LDA = 0000
  - ADD = 0001
  - SUB = 0010
  - OUT = 1110
  - HLT = 1111
  - Every other opcode is a NOP: the fetch runs, T4–T6 assert nothing.
- Control per T-state:
  - T1: Ep, Lm.
  - T2: Cp.
  - T3: CE, Li.
  - T4: LDA/ADD/SUB assert Ei, Lm. OUT asserts accumulator-send and Lo. HLT sets halted.
  - T5: LDA asserts CE and accumulator-load (La). ADD/SUB assert CE, Lb. OUT and HLT assert nothing.
  - T6: ADD asserts ALU-send and La. SUB asserts subtract, ALU-send and La. Others assert nothing.
- Bus drive:
  - o_bus_en = accumulator-send OR ALU-send.
  - o_bus = accumulator value when accumulator-send is active, otherwise the ALU result.
- ALU is combinational:
  - ADD result = acc + B, modulo 256.
  - SUB result = acc + ~B + 1, modulo 256.
  - Carry is discarded.
- Accumulator loads i_bus on a rising edge while La is asserted; otherwise it holds its value.
- Control outputs are combinational decodes of the T-state and i_opcode. All are 0 while halted, while i_program_mode = 0, and while i_reset_n = 0.

## Timing
- Reset (asynchronous):
  - T-state = T1 (o_tstate = 000001).
  - Accumulator = 0x00, o_halted = 0.
  - All control outputs, o_bus_en and o_bus read 0 while reset is held.
- T-state advances T1→T2→…→T6→T1 on each rising edge while i_program_mode = 1 and the block is not halted. One instruction takes 6 cycles.
- Program mode:
  - i_program_mode = 0 forces the T-state to T1 on the next edge and freezes it there.
  - Execution starts at T1 on the first edge after i_program_mode returns to 1.
- HLT:
  - o_halted is set on the rising edge that ends T4.
  - The T-state then freezes at T5 and all controls are 0.
  - Only reset clears the halted state.
- Load latency:
  - An LDA or ADD/SUB result is visible on o_acc one edge after its T5 or T6 respectively.
  - During T6 the accumulator loads the ALU result computed from its pre-edge value, so there is no combinational loop.
- Reset mid-instruction discards the instruction in progress. Execution restarts at T1 with the accumulator cleared.

## Configuration
- SAP_TRACE_EN defined: simulation `$display` messages for:
  - every T-state transition (state and opcode),
  - every accumulator load (new value),
  - every bus drive (value and source),
  - halt entry.
- SAP_TRACE_EN undefined: no trace code is compiled. Synthesised logic is identical either way.

## Test plan
- Reset then release with i_program_mode = 1 → o_tstate = 000001, o_acc = 0x00; in T1 only o_pc_enable and o_mar_load are high; T2 after one edge.
- LDA, with the bench driving i_bus = 0x2A in T5 → o_ram_enable and La high in T5; o_acc = 0x2A after the T5 edge; o_tstate back to T1 six edges after instruction start.
- ADD with acc = 0x2A, i_b = 0x10 and the bus looped back → T6 shows o_bus_en = 1, o_bus = 0x3A; o_acc = 0x3A afterwards. With acc = 0xF0, i_b = 0x20 the result wraps to 0x10.
- SUB with acc = 0x05, i_b = 0x07 → T6 o_bus = 0xFE; o_acc = 0xFE.
- OUT with acc = 0x5C → in T4 o_bus_en = 1, o_bus = 0x5C, o_out_load = 1; T5–T6 quiet.
- HLT → o_halted = 1 after T4 and the state is frozen with controls 0 for 10 edges. Dropping i_program_mode to 0 mid-instruction parks the state at T1. Asserting i_reset_n low mid-T3 gives T1 and o_acc = 0x00 immediately, without waiting for a clock edge.
